// File: rtl/dma_ipif_pkg.sv
// Shared types for the DMA IPIF master-port responder.
// No logic of its own; zero latency.
// No flow control; types and constants only.
package dma_ipif_pkg;

    localparam int IPIF_DW = 32;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        WAIT,
        DATA,
        CMPL
    } ipif_rsp_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } ipif_op_t;

    // Expand 4 byte enables into a 32-bit bit mask
    function automatic logic [IPIF_DW-1:0] be_to_mask(input logic [3:0] be);
        logic [IPIF_DW-1:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dma_ipif_regbank.sv
// NUM_REGS x 32 register bank with bytewise write, async read and per-register write strobe.
// Write lands on the clock edge ending the cycle wr_en_i is high; read is combinational.
// No backpressure: every write presented is accepted.
module dma_ipif_regbank
    import dma_ipif_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en_i,
    input  logic [$clog2(NUM_REGS)-1:0]   wr_idx_i,
    input  logic [3:0]                    wr_be_i,
    input  logic [IPIF_DW-1:0]            wr_dat_i,
    input  logic [$clog2(NUM_REGS)-1:0]   rd_idx_i,
    output logic [IPIF_DW-1:0]            rd_dat_o,
    output logic [NUM_REGS*IPIF_DW-1:0]   reg_flat_o,
    output logic [NUM_REGS-1:0]           wr_stb_o
);

    logic [IPIF_DW-1:0] mem_q [NUM_REGS];
    logic [IPIF_DW-1:0] wr_mask;

    assign wr_mask  = be_to_mask(wr_be_i);
    assign rd_dat_o = mem_q[rd_idx_i];

    // Bank storage: cleared on reset, masked byte update on write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= (mem_q[wr_idx_i] & ~wr_mask) | (wr_dat_i & wr_mask);
        end
    end

    // Flatten the bank for export to fabric
    always_comb begin
        reg_flat_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_flat_o[IPIF_DW*i +: IPIF_DW] = mem_q[i];
        end
    end

    // Strobe marks the register being written in this cycle (even if BE is partial)
    always_comb begin
        wr_stb_o = '0;
        if (wr_en_i) begin
            wr_stb_o[wr_idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/dma_ipif_mst_responder.sv
// Single-beat IPIF master-port responder serving 32-bit reads/writes against a local register bank.
// Latency: request seen at t -> CmdAck t+1 -> data t+2+ACK_LAT -> Cmplt t+3+ACK_LAT.
// Flow control is the IPIF handshake: one op in flight, 1 idle bubble after each Cmplt.
module dma_ipif_mst_responder
    import dma_ipif_pkg::*;
#(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h7000_0000,
    parameter int          ACK_LAT   = 2
) (
    input  logic                        axi_clk,
    input  logic                        rst,
    input  logic                        IP2Bus_MstRd_Req,
    input  logic                        IP2Bus_MstWr_Req,
    input  logic [31:0]                 IP2Bus_Mst_Addr,
    input  logic [3:0]                  IP2Bus_Mst_BE,
    input  logic                        IP2Bus_Mst_Lock,
    input  logic                        IP2Bus_Mst_Reset,
    output logic                        Bus2IP_Mst_CmdAck,
    output logic                        Bus2IP_Mst_Cmplt,
    output logic                        Bus2IP_Mst_Error,
    output logic                        Bus2IP_Mst_Rearbitrate,
    output logic                        Bus2IP_Mst_Timeout,
    output logic [IPIF_DW-1:0]          Bus2IP_MstRd_d,
    output logic                        Bus2IP_MstRd_src_rdy_n,
    input  logic [IPIF_DW-1:0]          IP2Bus_MstWr_d,
    output logic                        Bus2IP_MstWr_dst_rdy_n,
    output logic [NUM_REGS*IPIF_DW-1:0] reg_q,
    output logic [NUM_REGS-1:0]         reg_wr_stb,
    output logic [31:0]                 stat_rd_cnt,
    output logic [31:0]                 stat_wr_cnt,
    output logic [31:0]                 stat_err_cnt
);

    localparam int          IDX_W = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN  = 32'(NUM_REGS * 4);

    ipif_rsp_state_t   state_q, state_d;
    ipif_op_t          op_q, op_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        be_q, be_d;
    logic [3:0]        lat_q, lat_d;
    logic              bubble_q;
    logic [31:0]       rd_cnt_q, wr_cnt_q, err_cnt_q;

    logic [31:0]       offset;
    logic              dec_err;
    logic              rd_ph, wr_ph;
    logic [IPIF_DW-1:0] bank_rd;
    logic              unused_lock;

    // Lock is meaningless with a single master
    assign unused_lock = IP2Bus_Mst_Lock;

    // Address decode; a wrapped subtract turns addresses below the base into huge offsets
    assign offset  = IP2Bus_Mst_Addr - BASE_ADDR;
    assign dec_err = (IP2Bus_MstRd_Req && IP2Bus_MstWr_Req)
                   || (IP2Bus_Mst_Addr[1:0] != 2'b00)
                   || (offset >= SPAN)
                   || (IP2Bus_MstWr_Req && !IP2Bus_MstRd_Req && (IP2Bus_Mst_BE == 4'h0));

    // Next-state logic; master abort overrides everything, including a fresh accept
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        idx_d   = idx_q;
        be_d    = be_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE: begin
                if ((IP2Bus_MstRd_Req || IP2Bus_MstWr_Req) && !bubble_q) begin
                    state_d = ACK;
                    op_d    = (IP2Bus_MstWr_Req && !IP2Bus_MstRd_Req) ? OP_WR : OP_RD;
                    err_d   = dec_err;
                    idx_d   = offset[IDX_W+1:2];
                    be_d    = IP2Bus_Mst_BE;
                end
            end
            ACK: begin
                lat_d = 4'(ACK_LAT);
                if (ACK_LAT == 0) begin
                    state_d = err_q ? CMPL : DATA;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                lat_d = lat_q - 4'd1;
                if (lat_q <= 4'd1) begin
                    state_d = err_q ? CMPL : DATA;
                end
            end
            DATA:    state_d = CMPL;
            CMPL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (IP2Bus_Mst_Reset) begin
            state_d = IDLE;
        end
    end

    // FSM and latched command registers; bubble_q blocks accept in the cycle after CMPL
    always_ff @(posedge axi_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_RD;
            err_q    <= 1'b0;
            idx_q    <= '0;
            be_q     <= 4'h0;
            lat_q    <= 4'h0;
            bubble_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            be_q     <= be_d;
            lat_q    <= lat_d;
            bubble_q <= (state_q == CMPL);
        end
    end

    // Completion statistics, one increment per Cmplt
    always_ff @(posedge axi_clk) begin
        if (rst) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (state_q == CMPL) begin
            if (err_q)               err_cnt_q <= err_cnt_q + 32'd1;
            else if (op_q == OP_RD)  rd_cnt_q  <= rd_cnt_q + 32'd1;
            else                     wr_cnt_q  <= wr_cnt_q + 32'd1;
        end
    end

    assign rd_ph = (state_q == DATA) && !err_q && (op_q == OP_RD);
    assign wr_ph = (state_q == DATA) && !err_q && (op_q == OP_WR);

    assign Bus2IP_Mst_CmdAck      = (state_q == ACK);
    assign Bus2IP_Mst_Cmplt       = (state_q == CMPL);
    assign Bus2IP_Mst_Error       = (state_q == CMPL) && err_q;
    assign Bus2IP_Mst_Rearbitrate = 1'b0;
    assign Bus2IP_Mst_Timeout     = 1'b0;
    assign Bus2IP_MstRd_src_rdy_n = !rd_ph;
    assign Bus2IP_MstWr_dst_rdy_n = !wr_ph;
    assign Bus2IP_MstRd_d         = rd_ph ? bank_rd : '0;
    assign stat_rd_cnt            = rd_cnt_q;
    assign stat_wr_cnt            = wr_cnt_q;
    assign stat_err_cnt           = err_cnt_q;

    dma_ipif_regbank #(
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk        (axi_clk),
        .rst        (rst),
        .wr_en_i    (wr_ph),
        .wr_idx_i   (idx_q),
        .wr_be_i    (be_q),
        .wr_dat_i   (IP2Bus_MstWr_d),
        .rd_idx_i   (idx_q),
        .rd_dat_o   (bank_rd),
        .reg_flat_o (reg_q),
        .wr_stb_o   (reg_wr_stb)
    );

endmodule

// File: tb/tb_dma_ipif_mst_responder.sv
module tb_dma_ipif_mst_responder;

    localparam logic [31:0] BASE = 32'h7000_0000;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
        logic [15:0] stb;
        int          lat;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        rd_req, wr_req, mrst;
    logic [31:0] addr, wdat;
    logic [3:0]  be;

    logic        a_ack, a_cmplt, a_err, a_rearb, a_tmo, a_srn, a_drn;
    logic [31:0] a_rdd, a_rdc, a_wrc, a_errc;
    logic [511:0] a_regq;
    logic [15:0] a_stb;
    logic        b_ack, b_cmplt, b_err, b_rearb, b_tmo, b_srn, b_drn;
    logic [31:0] b_rdd, b_rdc, b_wrc, b_errc;
    logic [511:0] b_regq;
    logic [15:0] b_stb;

    logic        m_ack, m_cmplt, m_err, m_srn, m_drn;
    logic [31:0] m_rdd, m_rdc, m_wrc, m_errc;
    logic [511:0] m_regq;
    logic [15:0] m_stb;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dma_ipif_mst_responder #(.NUM_REGS(16), .BASE_ADDR(BASE), .ACK_LAT(2)) u_dut_a (
        .axi_clk(clk), .rst(rst),
        .IP2Bus_MstRd_Req(rd_req & ~sel), .IP2Bus_MstWr_Req(wr_req & ~sel),
        .IP2Bus_Mst_Addr(addr), .IP2Bus_Mst_BE(be), .IP2Bus_Mst_Lock(1'b0),
        .IP2Bus_Mst_Reset(mrst & ~sel),
        .Bus2IP_Mst_CmdAck(a_ack), .Bus2IP_Mst_Cmplt(a_cmplt), .Bus2IP_Mst_Error(a_err),
        .Bus2IP_Mst_Rearbitrate(a_rearb), .Bus2IP_Mst_Timeout(a_tmo),
        .Bus2IP_MstRd_d(a_rdd), .Bus2IP_MstRd_src_rdy_n(a_srn),
        .IP2Bus_MstWr_d(wdat), .Bus2IP_MstWr_dst_rdy_n(a_drn),
        .reg_q(a_regq), .reg_wr_stb(a_stb),
        .stat_rd_cnt(a_rdc), .stat_wr_cnt(a_wrc), .stat_err_cnt(a_errc)
    );

    dma_ipif_mst_responder #(.NUM_REGS(16), .BASE_ADDR(BASE), .ACK_LAT(0)) u_dut_b (
        .axi_clk(clk), .rst(rst),
        .IP2Bus_MstRd_Req(rd_req & sel), .IP2Bus_MstWr_Req(wr_req & sel),
        .IP2Bus_Mst_Addr(addr), .IP2Bus_Mst_BE(be), .IP2Bus_Mst_Lock(1'b0),
        .IP2Bus_Mst_Reset(mrst & sel),
        .Bus2IP_Mst_CmdAck(b_ack), .Bus2IP_Mst_Cmplt(b_cmplt), .Bus2IP_Mst_Error(b_err),
        .Bus2IP_Mst_Rearbitrate(b_rearb), .Bus2IP_Mst_Timeout(b_tmo),
        .Bus2IP_MstRd_d(b_rdd), .Bus2IP_MstRd_src_rdy_n(b_srn),
        .IP2Bus_MstWr_d(wdat), .Bus2IP_MstWr_dst_rdy_n(b_drn),
        .reg_q(b_regq), .reg_wr_stb(b_stb),
        .stat_rd_cnt(b_rdc), .stat_wr_cnt(b_wrc), .stat_err_cnt(b_errc)
    );

    assign m_ack   = sel ? b_ack   : a_ack;
    assign m_cmplt = sel ? b_cmplt : a_cmplt;
    assign m_err   = sel ? b_err   : a_err;
    assign m_srn   = sel ? b_srn   : a_srn;
    assign m_drn   = sel ? b_drn   : a_drn;
    assign m_rdd   = sel ? b_rdd   : a_rdd;
    assign m_rdc   = sel ? b_rdc   : a_rdc;
    assign m_wrc   = sel ? b_wrc   : a_wrc;
    assign m_errc  = sel ? b_errc  : a_errc;
    assign m_regq  = sel ? b_regq  : a_regq;
    assign m_stb   = sel ? b_stb   : a_stb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per Cmplt and checks what the op looked like
    int          ack_cyc = 0;
    int          last_cmplt = 0;
    int          strobes = 0;
    logic [15:0] stb_or = '0;
    logic [31:0] rd_seen = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            strobes = 0;
            stb_or  = '0;
        end else begin
            if (!m_srn || !m_drn || m_ack || m_cmplt)
                chk("strobe_excl", {30'd0, (!m_srn && !m_drn), (m_ack && m_cmplt)}, 32'd0);
            if (m_ack) begin
                ack_cyc = cyc;
                strobes = 0;
                stb_or  = '0;
            end
            stb_or = stb_or | m_stb;
            if (!m_srn) begin
                strobes++;
                rd_seen = m_rdd;
            end
            if (!m_drn) strobes++;
            if (m_cmplt) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_cmplt", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("cmplt_error", {31'd0, m_err}, {31'd0, e.err});
                    chk("data_strobes", strobes, e.err ? 0 : 1);
                    chk("reg_wr_stb", {16'd0, stb_or}, {16'd0, e.stb});
                    if (!e.err) chk("ack_to_cmplt", cyc - ack_cyc, e.lat);
                    if (e.rd && !e.err) chk("rd_data", rd_seen, e.data);
                    if (e.gap > 0) chk("b2b_gap", ack_cyc - last_cmplt, e.gap);
                end
                last_cmplt = cyc;
            end
        end
    end

    // Master model: holds the request until Cmplt, drops it after the Cmplt edge
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input bit exp_err, input logic [31:0] exp_data,
                         input logic [15:0] exp_stb, input int gap);
        exp_t e;
        bit got;
        e.err = exp_err; e.rd = rd && !wr; e.data = exp_data; e.stb = exp_stb;
        e.lat = sel ? 2 : 4; e.gap = gap;
        sbq.push_back(e);
        rd_req = rd; wr_req = wr; addr = a; be = b; wdat = d;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (m_cmplt) got = 1;
        end
        chk("cmplt_timeout", {31'd0, got}, 32'd1);
        if (!got) void'(sbq.pop_back());
        @(posedge clk); #1;
        rd_req = 0; wr_req = 0;
    endtask

    task automatic wait_ack();
        bit got;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (m_ack) got = 1;
        end
        chk("ack_timeout", {31'd0, got}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; sel = 0; rd_req = 0; wr_req = 0; mrst = 0;
        addr = '0; wdat = '0; be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack_cmplt_err", {29'd0, a_ack, a_cmplt, a_err}, 32'd0);
        chk("rst_rdy_n", {30'd0, a_srn, a_drn}, 32'd3);
        chk("rst_rd_d", a_rdd, 32'd0);
        chk("rst_bank_zero", {31'd0, (a_regq == '0) && (b_regq == '0)}, 32'd1);
        chk("rst_stb", {16'd0, a_stb}, 32'd0);
        chk("rst_cnts", a_rdc | a_wrc | a_errc, 32'd0);
        chk("tied_zero", {30'd0, a_rearb | b_rearb, a_tmo | b_tmo}, 32'd0);
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;

        // 1: full write, 2: read back
        do_op(0, 1, BASE + 32'h8, 4'hF, 32'hDEAD_BEEF, 0, 32'h0, 16'h0004, 0);
        chk("t1_reg2", m_regq[95:64], 32'hDEAD_BEEF);
        chk("t1_wr_cnt", m_wrc, 32'd1);
        do_op(1, 0, BASE + 32'h8, 4'h0, 32'h0, 0, 32'hDEAD_BEEF, 16'h0, 0);
        chk("t2_rd_cnt", m_rdc, 32'd1);

        // 3: partial write, bytes 0 and 2
        do_op(0, 1, BASE + 32'h8, 4'b0101, 32'h1122_3344, 0, 32'h0, 16'h0004, 0);
        chk("t3_reg2", m_regq[95:64], 32'hDE22_BE44);

        // 4: error cases
        do_op(1, 0, BASE + 32'h2,  4'hF, 32'h0, 1, 32'h0, 16'h0, 0);
        do_op(1, 0, BASE + 32'h40, 4'hF, 32'h0, 1, 32'h0, 16'h0, 0);
        do_op(1, 1, BASE + 32'h8,  4'hF, 32'hFFFF_FFFF, 1, 32'h0, 16'h0, 0);
        chk("t4_err_cnt", m_errc, 32'd3);
        do_op(0, 1, BASE + 32'h8,  4'h0, 32'hFFFF_FFFF, 1, 32'h0, 16'h0, 0);
        chk("t4_err_cnt_be0", m_errc, 32'd4);
        chk("t4_reg2_kept", m_regq[95:64], 32'hDE22_BE44);
        chk("t4_wr_cnt", m_wrc, 32'd2);

        // 5: master abort while in WAIT
        wr_req = 1; addr = BASE + 32'hC; be = 4'hF; wdat = 32'hCAFE_F00D;
        wait_ack();
        @(posedge clk); #1;
        mrst = 1; wr_req = 0;
        @(posedge clk); #1;
        mrst = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_reg3", m_regq[127:96], 32'd0);
        chk("t5_wr_cnt", m_wrc, 32'd2);
        do_op(1, 0, BASE + 32'hC, 4'hF, 32'h0, 0, 32'h0, 16'h0, 0);
        do_op(1, 0, BASE + 32'h8, 4'hF, 32'h0, 0, 32'hDE22_BE44, 16'h0, 0);
        chk("t5_rd_cnt", m_rdc, 32'd3);

        // 6: back-to-back on the ACK_LAT=0 instance
        sel = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++)
            do_op(0, 1, BASE + 32'(4 * i), 4'hF, 32'hA500_0000 | 32'(i), 0, 32'h0,
                  16'(1 << i), (i == 0) ? 0 : 3);
        for (int i = 0; i < 8; i++)
            do_op(1, 0, BASE + 32'(4 * i), 4'hF, 32'h0, 0, 32'hA500_0000 | 32'(i), 16'h0, 3);
        chk("t6_rd_cnt", m_rdc, 32'd8);
        chk("t6_wr_cnt", m_wrc, 32'd8);
        chk("t6_reg7", m_regq[255:224], 32'hA500_0007);

        // rst mid-transaction clears bank and counters
        sel = 0;
        @(posedge clk); #1;
        wr_req = 1; addr = BASE; be = 4'hF; wdat = 32'h1234_5678;
        wait_ack();
        @(posedge clk); #1;
        rst = 1; wr_req = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_mid_bank", {31'd0, a_regq == '0}, 32'd1);
        chk("rst_mid_cnts", a_rdc | a_wrc | a_errc, 32'd0);
        chk("sb_drained", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
